// File: rtl/cache_block_loader_if.sv
// Bundles the command, element-stream, RAM-write and status signals of the
// cache block loader; master is the command/stream source, slave is the loader.
interface cache_block_loader_if #(
  parameter int ELEMENT_WIDTH      = 32,
  parameter int ELEMENTS_PER_BLOCK = 4,
  parameter int LG_DEPTH           = 6
);
  logic                                        cmd_valid;
  logic                                        cmd_ready;
  logic [LG_DEPTH-1:0]                         cmd_base;
  logic [LG_DEPTH:0]                           cmd_blocks;
  logic                                        in_valid;
  logic                                        in_ready;
  logic [ELEMENT_WIDTH-1:0]                    in_data;
  logic                                        ram_en;
  logic                                        ram_we;
  logic [LG_DEPTH-1:0]                         ram_addr;
  logic [ELEMENT_WIDTH*ELEMENTS_PER_BLOCK-1:0] ram_din;
  logic                                        busy;
  logic                                        done;

  modport master (
    output cmd_valid, cmd_base, cmd_blocks, in_valid, in_data,
    input  cmd_ready, in_ready, ram_en, ram_we, ram_addr, ram_din, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_base, cmd_blocks, in_valid, in_data,
    output cmd_ready, in_ready, ram_en, ram_we, ram_addr, ram_din, busy, done
  );
endinterface

// File: rtl/cache_block_loader.sv
// Packs streamed element words into cache blocks and writes each finished
// block into one port of the configuration cache RAM at base+block (wrapping).
module cache_block_loader #(
  parameter int ELEMENT_WIDTH      = 32,
  parameter int ELEMENTS_PER_BLOCK = 4,
  parameter int LG_EPB             = 2,
  parameter int DEPTH              = 64,
  parameter int LG_DEPTH           = 6
) (
  input logic                 clk,
  input logic                 rst_n,
  cache_block_loader_if.slave bus
);
  localparam int                BLOCK_WIDTH = ELEMENT_WIDTH * ELEMENTS_PER_BLOCK;
  localparam logic [LG_DEPTH:0] MAX_BLOCKS  = (LG_DEPTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [LG_EPB-1:0]      ecnt;
  logic [LG_DEPTH-1:0]    bcnt;
  logic [LG_DEPTH-1:0]    base;
  logic [LG_DEPTH:0]      count;
  logic [BLOCK_WIDTH-1:0] buffer;
  logic                   cmd_fire;
  logic                   in_fire;
  logic                   last_block;

  assign cmd_fire   = (state == IDLE) && bus.cmd_valid;
  assign in_fire    = (state == FILL) && bus.in_valid;
  assign last_block = ({1'b0, bcnt} == count - (LG_DEPTH+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake and RAM strobes come only from the registered state, so no
  // output has a combinational path from cmd_valid or in_valid.
  always_comb begin
    state_next    = state;
    bus.cmd_ready = 1'b0;
    bus.in_ready  = 1'b0;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          state_next = (bus.cmd_blocks == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (bus.in_valid && (&ecnt)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        bus.ram_en = 1'b1;
        bus.ram_we = 1'b1;
        bus.busy   = 1'b1;
        state_next = last_block ? DONE : FILL;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.ram_addr = base + bcnt;
  assign bus.ram_din  = buffer;

  // ecnt wraps to lane 0 by itself after the last lane since the block size
  // is a power of two; out-of-range counts are clamped to a full sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt   <= '0;
      bcnt   <= '0;
      base   <= '0;
      count  <= '0;
      buffer <= '0;
    end else begin
      if (cmd_fire) begin
        base  <= bus.cmd_base;
        count <= (bus.cmd_blocks > MAX_BLOCKS) ? MAX_BLOCKS : bus.cmd_blocks;
        ecnt  <= '0;
        bcnt  <= '0;
      end
      if (in_fire) begin
        buffer[int'(ecnt)*ELEMENT_WIDTH +: ELEMENT_WIDTH] <= bus.in_data;
        ecnt <= ecnt + LG_EPB'(1);
      end
      if ((state == WRITE) && !last_block) begin
        bcnt <= bcnt + LG_DEPTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_cache_block_loader.sv
// Scoreboard bench for cache_block_loader: expected RAM writes are modelled
// from the element stream and compared against the writes the DUT issues.
module tb_cache_block_loader;
  localparam int W   = 32;
  localparam int EPB = 4;
  localparam int LGD = 6;

  typedef struct packed {
    logic [LGD-1:0]   addr;
    logic [W*EPB-1:0] din;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   en_cnt      = 0;
  int   busy_cnt    = 0;
  int   bad_inready = 0;
  int   rd_idx      = 0;
  wr_t  got_q[$];
  wr_t  exp_q[$];
  int   acc_q[$];
  logic [W-1:0] elem_q[$];

  cache_block_loader_if #(.ELEMENT_WIDTH(W), .ELEMENTS_PER_BLOCK(EPB), .LG_DEPTH(LGD)) bus ();

  cache_block_loader #(
    .ELEMENT_WIDTH(W), .ELEMENTS_PER_BLOCK(EPB), .LG_EPB(2), .DEPTH(64), .LG_DEPTH(LGD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every RAM write, accepted command and strobe count.
  always @(negedge clk) begin
    if (bus.ram_en) en_cnt++;
    if (bus.busy) busy_cnt++;
    if (bus.ram_we) begin
      got_q.push_back({bus.ram_addr, bus.ram_din});
      if (bus.in_ready) bad_inready++;
    end
    if (bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc);
  end

  task automatic fill_elems(input logic [W-1:0] first, input logic [W-1:0] step, input int n);
    elem_q.delete();
    for (int i = 0; i < n; i++) elem_q.push_back(first + step * W'(i));
  endtask

  task automatic expect_blocks(input logic [LGD-1:0] b, input int n);
    for (int blk = 0; blk < n; blk++) begin
      wr_t e;
      e.addr = b + LGD'(blk);
      e.din  = '0;
      for (int l = 0; l < EPB; l++) e.din[l*W +: W] = elem_q[blk*EPB+l];
      exp_q.push_back(e);
    end
  endtask

  task automatic send_cmd(input logic [LGD-1:0] b, input logic [LGD:0] n, output int t);
    t = -1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_base   = b;
    bus.cmd_blocks = n;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        t = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    if (t < 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL cmd_accept: command not accepted within 100 cycles");
    end
  endtask

  task automatic feed(input bit gaps);
    int i     = 0;
    int guard = 0;
    while (i < elem_q.size() && guard < 1000) begin
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = elem_q[i];
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) i++;
      @(posedge clk);
      #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (i < elem_q.size()) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL feed: only %0d of %0d elements accepted", i, elem_q.size());
    end
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.done) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_wait: no done pulse within 300 cycles");
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({bus.cmd_ready, bus.in_ready, bus.ram_en, bus.ram_we, bus.busy, bus.done} !== 6'b100000) begin
      miscompares++;
      $display("[TB] FAIL reset_strobes: got %b expected 100000",
               {bus.cmd_ready, bus.in_ready, bus.ram_en, bus.ram_we, bus.busy, bus.done});
    end
    vectors++;
    if (bus.ram_addr !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_addr: got %h expected 0", bus.ram_addr);
    end
    vectors++;
    if (bus.ram_din !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_din: got %h expected 0", bus.ram_din);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_block();
    int ta, td, en0, b0;
    wr_t e;
    en0 = en_cnt;
    b0  = busy_cnt;
    fill_elems(32'h11, 32'h11, 4);
    expect_blocks(6'd3, 1);
    send_cmd(6'd3, 7'd1, ta);
    feed(1'b0);
    wait_done(td);
    vectors++;
    if (td - ta !== 6) begin
      miscompares++;
      $display("[TB] FAIL single_latency: got %0d expected 6", td - ta);
    end
    vectors++;
    if (busy_cnt - b0 !== 5) begin
      miscompares++;
      $display("[TB] FAIL single_busy: got %0d busy cycles expected 5", busy_cnt - b0);
    end
    vectors++;
    if (en_cnt - en0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL single_en_count: got %0d expected 1", en_cnt - en0);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (rd_idx >= got_q.size()) begin
        miscompares++;
        $display("[TB] FAIL single_write: missing write, expected addr %h din %h", e.addr, e.din);
      end else begin
        if (got_q[rd_idx] !== e) begin
          miscompares++;
          $display("[TB] FAIL single_write: got addr %h din %h expected addr %h din %h",
                   got_q[rd_idx].addr, got_q[rd_idx].din, e.addr, e.din);
        end
        rd_idx++;
      end
    end
    rd_idx = got_q.size();
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    int ta, td, w0;
    wr_t e;
    w0 = got_q.size();
    fill_elems(32'h100, 32'h1, 12);
    expect_blocks(6'd62, 3);
    send_cmd(6'd62, 7'd3, ta);
    feed(1'b0);
    wait_done(td);
    vectors++;
    if (td - ta !== 16) begin
      miscompares++;
      $display("[TB] FAIL wrap_latency: got %0d expected 16", td - ta);
    end
    vectors++;
    if (got_q.size() - w0 !== 3) begin
      miscompares++;
      $display("[TB] FAIL wrap_write_count: got %0d expected 3", got_q.size() - w0);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (rd_idx >= got_q.size()) begin
        miscompares++;
        $display("[TB] FAIL wrap_write: missing write, expected addr %h din %h", e.addr, e.din);
      end else begin
        if (got_q[rd_idx] !== e) begin
          miscompares++;
          $display("[TB] FAIL wrap_write: got addr %h din %h expected addr %h din %h",
                   got_q[rd_idx].addr, got_q[rd_idx].din, e.addr, e.din);
        end
        rd_idx++;
      end
    end
    rd_idx = got_q.size();
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_blocks();
    int ta, td, en0;
    en0 = en_cnt;
    send_cmd(6'd9, 7'd0, ta);
    wait_done(td);
    vectors++;
    if (td - ta !== 1) begin
      miscompares++;
      $display("[TB] FAIL zero_latency: got %0d expected 1", td - ta);
    end
    @(negedge clk);
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL zero_ready_after: got %b expected 1", bus.cmd_ready);
    end
    vectors++;
    if (en_cnt - en0 !== 0) begin
      miscompares++;
      $display("[TB] FAIL zero_ram_en: got %0d enables expected 0", en_cnt - en0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_gaps();
    int ta, td, bad0;
    wr_t e;
    bad0 = bad_inready;
    fill_elems(32'h200, 32'h3, 16);
    for (int pass = 0; pass < 2; pass++) begin
      expect_blocks(6'd10, 4);
      send_cmd(6'd10, 7'd4, ta);
      feed(pass == 1);
      wait_done(td);
      if (pass == 0) begin
        vectors++;
        if (td - ta !== 21) begin
          miscompares++;
          $display("[TB] FAIL gapfree_latency: got %0d expected 21", td - ta);
        end
      end
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (rd_idx >= got_q.size()) begin
          miscompares++;
          $display("[TB] FAIL gaps_write pass %0d: missing, expected addr %h din %h", pass, e.addr, e.din);
        end else begin
          if (got_q[rd_idx] !== e) begin
            miscompares++;
            $display("[TB] FAIL gaps_write pass %0d: got addr %h din %h expected addr %h din %h",
                     pass, got_q[rd_idx].addr, got_q[rd_idx].din, e.addr, e.din);
          end
          rd_idx++;
        end
      end
      vectors++;
      if (got_q.size() !== rd_idx) begin
        miscompares++;
        $display("[TB] FAIL gaps_extra_writes pass %0d: got %0d expected %0d", pass, got_q.size(), rd_idx);
      end
      rd_idx = got_q.size();
      @(posedge clk);
      #1;
    end
    vectors++;
    if (bad_inready - bad0 !== 0) begin
      miscompares++;
      $display("[TB] FAIL write_in_ready: got %0d WRITE cycles with in_ready expected 0", bad_inready - bad0);
    end
  endtask

  task automatic test_back_to_back();
    int ta, td, tb2, na0;
    wr_t e;
    fill_elems(32'h300, 32'h1, 4);
    expect_blocks(6'd20, 1);
    send_cmd(6'd20, 7'd1, ta);
    na0 = acc_q.size();
    bus.cmd_valid  = 1'b1;
    bus.cmd_base   = 6'd40;
    bus.cmd_blocks = 7'd2;
    feed(1'b0);
    wait_done(td);
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    vectors++;
    if (acc_q.size() - na0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL held_cmd_accepts: got %0d accepts expected 1", acc_q.size() - na0);
    end else begin
      vectors++;
      if (acc_q[acc_q.size()-1] !== td + 1) begin
        miscompares++;
        $display("[TB] FAIL held_cmd_cycle: got %0d expected %0d", acc_q[acc_q.size()-1], td + 1);
      end
    end
    fill_elems(32'h400, 32'h5, 8);
    expect_blocks(6'd40, 2);
    feed(1'b0);
    wait_done(tb2);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (rd_idx >= got_q.size()) begin
        miscompares++;
        $display("[TB] FAIL b2b_write: missing write, expected addr %h din %h", e.addr, e.din);
      end else begin
        if (got_q[rd_idx] !== e) begin
          miscompares++;
          $display("[TB] FAIL b2b_write: got addr %h din %h expected addr %h din %h",
                   got_q[rd_idx].addr, got_q[rd_idx].din, e.addr, e.din);
        end
        rd_idx++;
      end
    end
    rd_idx = got_q.size();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midblock();
    int ta, td, en0, w0;
    wr_t e;
    en0 = en_cnt;
    w0  = got_q.size();
    fill_elems(32'h500, 32'h1, 2);
    send_cmd(6'd5, 7'd1, ta);
    feed(1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.cmd_ready, bus.in_ready, bus.ram_en, bus.ram_we, bus.busy, bus.done} !== 6'b100000) begin
      miscompares++;
      $display("[TB] FAIL async_reset_strobes: got %b expected 100000",
               {bus.cmd_ready, bus.in_ready, bus.ram_en, bus.ram_we, bus.busy, bus.done});
    end
    vectors++;
    if (bus.ram_din !== '0 || bus.ram_addr !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_data: got addr %h din %h expected 0", bus.ram_addr, bus.ram_din);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (en_cnt - en0 !== 0 || got_q.size() !== w0) begin
      miscompares++;
      $display("[TB] FAIL reset_no_write: got %0d enables expected 0", en_cnt - en0);
    end
    fill_elems(32'hA, 32'h1, 4);
    expect_blocks(6'd7, 1);
    send_cmd(6'd7, 7'd1, ta);
    feed(1'b0);
    wait_done(td);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (rd_idx >= got_q.size()) begin
        miscompares++;
        $display("[TB] FAIL post_reset_write: missing write, expected addr %h din %h", e.addr, e.din);
      end else begin
        if (got_q[rd_idx] !== e) begin
          miscompares++;
          $display("[TB] FAIL post_reset_write: got addr %h din %h expected addr %h din %h",
                   got_q[rd_idx].addr, got_q[rd_idx].din, e.addr, e.din);
        end
        rd_idx++;
      end
    end
    rd_idx = got_q.size();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_base   = '0;
    bus.cmd_blocks = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    test_reset();
    test_single_block();
    test_wrap();
    test_zero_blocks();
    test_gaps();
    test_back_to_back();
    test_reset_midblock();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
